// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : EX-stage ALU with registered ALU-control decode and a
//             valid/ready handshake. Decodes ALUOP/funct fields into a 4-bit
//             control code and returns a registered result one cycle later.
//  Options  : ALU_MUL_EN - adds an iterative shift-add multiplier (RV32M MUL);
//             the unit then goes busy for XLEN cycles per multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic            op5,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_control,
  output logic            out_valid,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLTU = 4'b0110;
  localparam logic [3:0] C_SLL  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_MUL  = 4'b1010;

  logic [3:0]      w_ctrl;
  logic [XLEN-1:0] w_res;
  logic [SH_W-1:0] w_shamt;
  logic            w_accept;

  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            out_valid_q, out_valid_d;

  assign w_shamt = src_b[SH_W-1:0];

  // Decode ALUOP and the instruction function fields into a control code
  always_comb begin
    w_ctrl = C_ADD;
    if (aluop == 2'b01) begin
      w_ctrl = C_SUB;
    end else if (aluop == 2'b10) begin
      case (funct3)
        3'b000: begin
`ifdef ALU_MUL_EN
          if (op5 && funct7_0)       w_ctrl = C_MUL;
          else if (op5 && funct7_5)  w_ctrl = C_SUB;
          else                       w_ctrl = C_ADD;
`else
          w_ctrl = (op5 && funct7_5) ? C_SUB : C_ADD;
`endif
        end
        3'b001:  w_ctrl = C_SLL;
        3'b010:  w_ctrl = C_SLT;
        3'b011:  w_ctrl = C_SLTU;
        3'b100:  w_ctrl = C_XOR;
        3'b101:  w_ctrl = funct7_5 ? C_SRA : C_SRL;
        3'b110:  w_ctrl = C_OR;
        default: w_ctrl = C_AND;
      endcase
    end
  end

  // Single-cycle datapath; MUL is produced by the iterative unit instead
  always_comb begin
    w_res = '0;
    case (w_ctrl)
      C_ADD:  w_res = src_a + src_b;
      C_SUB:  w_res = src_a - src_b;
      C_AND:  w_res = src_a & src_b;
      C_OR:   w_res = src_a | src_b;
      C_XOR:  w_res = src_a ^ src_b;
      C_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_SLTU: w_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      C_SLL:  w_res = src_a << w_shamt;
      C_SRL:  w_res = src_a >> w_shamt;
      C_SRA:  w_res = $unsigned($signed(src_a) >>> w_shamt);
      default: w_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] w_acc_next;

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_MUL);
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state: accept/issue in IDLE, one shift-add step per cycle in MUL
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_MUL) begin
      acc_d    = w_acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == C_LAST) begin
        result_d    = w_acc_next;
        zero_d      = (w_acc_next == '0);
        ctrl_d      = C_MUL;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
    end else if (w_accept) begin
      if (w_ctrl == C_MUL) begin
        mcand_d  = src_a;
        mplier_d = src_b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ST_MUL;
      end else begin
        result_d    = w_res;
        zero_d      = (w_res == '0);
        ctrl_d      = w_ctrl;
        out_valid_d = 1'b1;
      end
    end
  end

  // State and multiplier registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  logic w_unused_funct7_0;

  assign w_unused_funct7_0 = funct7_0;
  assign in_ready          = 1'b1;
  assign busy              = 1'b0;
  assign w_accept          = in_valid && !flush;

  // Next-state: every accepted op completes in one cycle
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    if (w_accept) begin
      result_d    = w_res;
      zero_d      = (w_res == '0);
      ctrl_d      = w_ctrl;
      out_valid_d = 1'b1;
    end
  end
`endif

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      ctrl_q      <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign alu_control = ctrl_q;
  assign out_valid   = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit: directed corner cases,
//             flush/reset behaviour and randomized ops against a reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int XLEN = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_AND  = 4'd2;
  localparam logic [3:0] C_OR   = 4'd3;
  localparam logic [3:0] C_XOR  = 4'd4;
  localparam logic [3:0] C_SLT  = 4'd5;
  localparam logic [3:0] C_SLTU = 4'd6;
  localparam logic [3:0] C_SLL  = 4'd7;
  localparam logic [3:0] C_SRL  = 4'd8;
  localparam logic [3:0] C_SRA  = 4'd9;
  localparam logic [3:0] C_MUL  = 4'd10;

  logic            clk, rst_n, in_valid, in_ready, flush;
  logic [1:0]      aluop;
  logic [2:0]      funct3;
  logic            op5, funct7_5, funct7_0;
  logic [XLEN-1:0] src_a, src_b, result;
  logic            zero, out_valid, busy;
  logic [3:0]      alu_control;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] last_res;
  logic [3:0]      last_ctrl;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .aluop(aluop), .funct3(funct3), .op5(op5),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .src_a(src_a), .src_b(src_b),
    .result(result), .zero(zero), .alu_control(alu_control),
    .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instruction-level semantics with plain arithmetic
  function automatic void ref_op(input logic [1:0] ao, input logic [2:0] f3,
                                 input logic o5, input logic f75, input logic f70,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [3:0] code, output logic [31:0] res);
    int unsigned sh;
    longint unsigned prod;
    logic [31:0] pow2;
    sh   = int'(b % 32);
    pow2 = 32'd1 << sh;
    if (ao == 2'b01)                            code = C_SUB;
    else if (ao != 2'b10)                       code = C_ADD;
    else if (MUL_EN && f3 == 3'd0 && o5 && f70) code = C_MUL;
    else begin
      case (f3)
        3'd0: code = (o5 && f75) ? C_SUB : C_ADD;
        3'd1: code = C_SLL;
        3'd2: code = C_SLT;
        3'd3: code = C_SLTU;
        3'd4: code = C_XOR;
        3'd5: code = f75 ? C_SRA : C_SRL;
        3'd6: code = C_OR;
        default: code = C_AND;
      endcase
    end
    case (code)
      C_ADD:  res = a + b;
      C_SUB:  res = a - b;
      C_AND:  res = a & b;
      C_OR:   res = a | b;
      C_XOR:  res = a ^ b;
      C_SLT:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      C_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      C_SLL:  begin prod = longint'(a) * longint'(pow2); res = prod[31:0]; end
      C_SRL:  res = a / pow2;
      C_SRA:  res = a[31] ? ~((~a) / pow2) : a / pow2;
      default: begin prod = longint'(a) * longint'(b); res = prod[31:0]; end
    endcase
  endfunction

  // Issue one op and check its response (waits out the multiply if needed)
  task automatic do_op(input logic [1:0] ao, input logic [2:0] f3, input logic o5,
                       input logic f75, input logic f70,
                       input logic [31:0] a, input logic [31:0] b);
    logic [3:0]  ecode;
    logic [31:0] eres;
    int bad;
    ref_op(ao, f3, o5, f75, f70, a, b, ecode, eres);
    aluop = ao; funct3 = f3; op5 = o5; funct7_5 = f75; funct7_0 = f70;
    src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ecode == C_MUL) begin
      bad = 0;
      for (int k = 0; k < XLEN; k++) begin
        if (!(busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0)) bad++;
        @(posedge clk); #1;
      end
      check_eq("mul_busy_window", 64'(bad), 64'd0);
    end
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("result", 64'(result), 64'(eres));
    check_eq("zero", 64'(zero), 64'(eres == 32'd0));
    check_eq("alu_control", 64'(alu_control), 64'(ecode));
    check_eq("in_ready", 64'(in_ready), 64'd1);
    last_res  = eres;
    last_ctrl = ecode;
  endtask

  task automatic count_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; aluop = 2'b00; funct3 = 3'd0;
    op5 = 1'b0; funct7_5 = 1'b0; funct7_0 = 1'b0; src_a = '0; src_b = '0;
    last_res = '0; last_ctrl = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_zero", 64'(zero), 64'd0);
    check_eq("rst_alu_control", 64'(alu_control), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed single-cycle ops
    do_op(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7);
    check_eq("sub_literal", 64'(result), 64'hFFFF_FFFE);
    do_op(2'b10, 3'b011, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check_eq("sltu_literal", 64'(result), 64'd0);
    do_op(2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check_eq("slt_literal", 64'(result), 64'd1);
    do_op(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0024);
    check_eq("sra_literal", 64'(result), 64'hF800_0000);
    do_op(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0024);
    check_eq("srl_literal", 64'(result), 64'h0800_0000);
    do_op(2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 32'd3, 32'hFFFF_FFFD);
    check_eq("add_zero_literal", 64'(zero), 64'd1);
    do_op(2'b11, 3'b100, 1'b1, 1'b1, 1'b0, 32'd9, 32'd4);
    do_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd4, 32'd9);
    // funct7_0 set: MUL when compiled in, plain ADD otherwise
    do_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd6, 32'd7);
    check_eq("f7_0_result", 64'(result), MUL_EN ? 64'd42 : 64'd13);
    // funct7_0 with a non-zero funct3 is ignored
    do_op(2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'h00F0, 32'h0F00);

    // FLUSH together with an ADD: dropped, outputs held
    do_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1);
    aluop = 2'b00; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_add_valid", 64'(out_valid), 64'd0);
    check_eq("flush_add_result", 64'(result), 64'(last_res));
    check_eq("flush_add_ctrl", 64'(alu_control), 64'(last_ctrl));
    count_no_valid("flush_add_later_valid", 3);

    if (MUL_EN) begin
      // Wrapped multiply with an op held pending through the busy window
      aluop = 2'b10; funct3 = 3'b000; op5 = 1'b1; funct7_5 = 1'b0; funct7_0 = 1'b1;
      src_a = 32'h0001_0001; src_b = 32'h0001_0000; in_valid = 1'b1;
      @(posedge clk); #1;
      aluop = 2'b00; funct7_0 = 1'b0; src_a = 32'd1; src_b = 32'd2;
      cnt = 0;
      for (int k = 0; k < XLEN; k++) begin
        if (in_ready === 1'b0 && out_valid === 1'b0) cnt++;
        @(posedge clk); #1;
      end
      check_eq("mul_ready_low_cycles", 64'(cnt), 64'(XLEN));
      check_eq("mul_out_valid", 64'(out_valid), 64'd1);
      check_eq("mul_result", 64'(result), 64'h0001_0000);
      check_eq("mul_ctrl", 64'(alu_control), 64'(C_MUL));
      check_eq("mul_ready_again", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("held_add_valid", 64'(out_valid), 64'd1);
      check_eq("held_add_result", 64'(result), 64'd3);
      last_res = 32'd3; last_ctrl = C_ADD;

      // FLUSH at multiply cycle 5
      aluop = 2'b10; funct3 = 3'b000; op5 = 1'b1; funct7_0 = 1'b1;
      src_a = 32'd11; src_b = 32'd13; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check_eq("mul_busy_before_flush", 64'(busy), 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_eq("flush_mul_busy", 64'(busy), 64'd0);
      check_eq("flush_mul_ready", 64'(in_ready), 64'd1);
      check_eq("flush_mul_valid", 64'(out_valid), 64'd0);
      count_no_valid("flush_mul_later_valid", XLEN + 4);
      check_eq("flush_mul_result", 64'(result), 64'(last_res));
      check_eq("flush_mul_ctrl", 64'(alu_control), 64'(last_ctrl));

      // Async reset at multiply cycle 10
      src_a = 32'd21; src_b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; funct7_0 = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
    end else begin
      // Async reset right after a result is registered
      aluop = 2'b00; src_a = 32'd21; src_b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_result", 64'(result), 64'd0);
    check_eq("midrst_ctrl", 64'(alu_control), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    #3 rst_n = 1'b1;
    count_no_valid("midrst_later_valid", XLEN + 8);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      do_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
